// File: rtl/pmem_line_adapter_pkg.sv
// Shared types for the cache physical-memory port and its word-wide memory bus.
package pmem_line_adapter_pkg;

  typedef logic [127:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [2:0]   lc3b_word_sel;
  typedef logic [11:0]  lc3b_line_addr;

  typedef enum logic [1:0] {
    pmem_idle,
    pmem_read_s,
    pmem_write_s,
    pmem_done
  } lc3b_pmem_state;

  function automatic lc3b_word block_word(lc3b_block blk, lc3b_word_sel sel);
    return blk[{sel, 4'b0000} +: 16];
  endfunction

  function automatic lc3b_word word_address(lc3b_line_addr line, lc3b_word_sel sel);
    return {line, sel, 1'b0};
  endfunction

endpackage

// File: rtl/pmem_line_adapter_if.sv
// Cache-side line port plus word-wide memory bus; slave is the adapter's view.
interface pmem_line_adapter_if;
  import pmem_line_adapter_pkg::*;

  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  lc3b_block     pmem_wdata;
  lc3b_block     pmem_rdata;
  logic          pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [15:0]   mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata,
           mem_byte_enable
  );

endinterface

// File: rtl/pmem_line_adapter_line_assembler.sv
// Fill-line register: writes one 16-bit word into the selected slot per load, 1-cycle latency.
module line_assembler
  import pmem_line_adapter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  lc3b_word_sel slot,
  input  logic         load,
  input  lc3b_word     word,
  output lc3b_block    line
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (load) begin
      line[{slot, 4'b0000} +: 16] <= word;
    end
  end

endmodule

// File: rtl/pmem_line_adapter.sv
// Splits one 128-bit line read/write into eight 16-bit memory transactions; pmem_resp
// pulses one cycle after the eighth mem_resp. Memory stalls by withholding mem_resp.
module pmem_line_adapter
  import pmem_line_adapter_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input logic               clk,
  input logic               rst_n,
  pmem_line_adapter_if.slave bus
);

  localparam lc3b_word_sel LAST_SEL = lc3b_word_sel'(LINE_WORDS - 1);

  lc3b_pmem_state state;
  lc3b_word_sel   cnt;
  lc3b_word_sel   next_sel;
  lc3b_line_addr  line_addr;
  lc3b_block      wline;
  logic           unused_addr_bits;

  assign next_sel         = cnt + 3'd1;
  assign unused_addr_bits = ^bus.pmem_address[3:0];

  line_assembler u_line_assembler (
    .clk  (clk),
    .rst_n(rst_n),
    .slot (cnt),
    .load (bus.mem_resp && (state == pmem_read_s)),
    .word (bus.mem_rdata),
    .line (bus.pmem_rdata)
  );

  // Outputs are registered, so each word's address/data is prepared from next_sel
  // on the edge that retires the previous word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= pmem_idle;
      cnt                 <= '0;
      line_addr           <= '0;
      wline               <= '0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= 2'b00;
      bus.pmem_resp       <= 1'b0;
    end else begin
      case (state)
        pmem_idle: begin
          cnt <= '0;
          if (bus.pmem_write) begin
            state               <= pmem_write_s;
            line_addr           <= bus.pmem_address[15:4];
            wline               <= bus.pmem_wdata;
            bus.mem_write       <= 1'b1;
            bus.mem_byte_enable <= 2'b11;
            bus.mem_address     <= word_address(bus.pmem_address[15:4], 3'd0);
            bus.mem_wdata       <= bus.pmem_wdata[15:0];
          end else if (bus.pmem_read) begin
            state           <= pmem_read_s;
            line_addr       <= bus.pmem_address[15:4];
            bus.mem_read    <= 1'b1;
            bus.mem_address <= word_address(bus.pmem_address[15:4], 3'd0);
          end
        end

        pmem_read_s, pmem_write_s: begin
          if (bus.mem_resp) begin
            cnt <= next_sel;
            if (cnt == LAST_SEL) begin
              state               <= pmem_done;
              bus.mem_read        <= 1'b0;
              bus.mem_write       <= 1'b0;
              bus.mem_byte_enable <= 2'b00;
              bus.mem_address     <= '0;
              bus.mem_wdata       <= '0;
              bus.pmem_resp       <= 1'b1;
            end else begin
              bus.mem_address <= word_address(line_addr, next_sel);
              bus.mem_wdata   <= (state == pmem_write_s) ? block_word(wline, next_sel) : '0;
            end
          end
        end

        pmem_done: begin
          state         <= pmem_idle;
          bus.pmem_resp <= 1'b0;
        end

        default: state <= pmem_idle;
      endcase
    end
  end

endmodule
